clock_setter: RTL and testbench

CLOCK_SETTER -- requirements
Module: clock_setter

---
 rtl/clock_setter.sv | 232 +++++++++++++++++++++++
 tb/tb_clock_setter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_setter.sv
// -----------------------------------------------------------------------------
// clock_setter
//
// Front-panel controller for a 24-hour clock with one alarm. Two raw push
// buttons (mode, inc) are synchronized, debounced and turned into single-cycle
// press events. A six-state mode machine lets the user edit the clock time and
// the alarm time/enable. When the user leaves minute editing, the edited time
// is handed to the clock with a one-cycle load strobe.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed before a debounced button
//                    level follows the synchronized input (2..255)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   btn_mode   in   1  raw mode button, high = pressed
//   btn_inc    in   1  raw increment button, high = pressed
//   cur_hour   in   5  live clock hour (0..23), captured when editing starts
//   cur_min    in   6  live clock minute (0..59), captured when editing starts
//   set_hour   out  5  hour to write into the clock
//   set_min    out  6  minute to write into the clock
//   load       out  1  one-cycle strobe: clock takes set_hour/set_min
//   alarm_hr   out  5  alarm hour (0..23)
//   alarm_min  out  6  alarm minute (0..59)
//   alarm_en   out  1  alarm enable
//   mode       out  3  current state code, used by the display for blinking
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// clock_setter_btn
//
// One button conditioning channel: 2-flop synchronizer, counter-based
// debouncer and rising-edge detector on the debounced level.
//
// Ports
//   clk    in   1  clock
//   rst    in   1  synchronous, active-high reset
//   btn    in   1  raw asynchronous button
//   press  out  1  one-cycle event on each debounced 0->1 transition
// -----------------------------------------------------------------------------
module clock_setter_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  // Count value reached on the last required mismatch cycle.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync_a;
  logic       sync_b;
  logic       level;
  logic       level_q;
  logic [7:0] cnt;

  // NOTE: every register in a clocked block is assigned with <= so that all
  // flops sample the values from before the edge; '=' here would let the
  // second synchronizer stage see the first stage's new value in the same
  // cycle and collapse the synchronizer to a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      sync_a  <= btn;
      sync_b  <= sync_a;
      level_q <= level;
      if (sync_b != level) begin
        // Input disagrees with the debounced level: count consecutive cycles
        // and flip the level once the full run has been seen.
        if (cnt == CNT_LAST) begin
          level <= sync_b;
          cnt   <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        // Any agreeing cycle breaks the run.
        cnt <= 8'd0;
      end
    end
  end

  // level_q lags level by one cycle, so this is high for exactly one cycle
  // per debounced press no matter how long the button is held.
  assign press = level & ~level_q;

endmodule

module clock_setter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic       load,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic [2:0] mode
);

  // State codes double as the mode output seen by the display.
  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_SET_HR  = 3'd1;
  localparam logic [2:0] ST_SET_MIN = 3'd2;
  localparam logic [2:0] ST_ALM_HR  = 3'd3;
  localparam logic [2:0] ST_ALM_MIN = 3'd4;
  localparam logic [2:0] ST_ALM_EN  = 3'd5;

  logic [2:0] state;
  logic       mode_ev;
  logic       inc_ev;
  logic       inc_eff;

  logic [4:0] set_hour_nx;
  logic [5:0] set_min_nx;
  logic [4:0] alarm_hr_nx;
  logic [5:0] alarm_min_nx;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  clock_setter_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_mode (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_mode),
    .press(mode_ev)
  );

  clock_setter_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_inc (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_inc),
    .press(inc_ev)
  );

  // A mode press in the same cycle swallows the increment.
  assign inc_eff = inc_ev & ~mode_ev;

  // ---------------------------------------------------------------------------
  // Wrapping increments, kept at the field widths and wrapped by comparing
  // against the last legal value.
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] next_hour(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] next_min(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  // NOTE: each combinational output is given its value unconditionally at the
  // top of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    set_hour_nx  = next_hour(set_hour);
    set_min_nx   = next_min(set_min);
    alarm_hr_nx  = next_hour(alarm_hr);
    alarm_min_nx = next_min(alarm_min);
  end

  // ---------------------------------------------------------------------------
  // Mode machine and edited registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      set_hour  <= 5'd0;
      set_min   <= 6'd0;
      load      <= 1'b0;
      alarm_hr  <= 5'd0;
      alarm_min <= 6'd0;
      alarm_en  <= 1'b0;
    end else begin
      // load is a strobe: it is only raised for the single cycle after the
      // SET_MIN exit below.
      load <= 1'b0;

      if (mode_ev) begin
        case (state)
          ST_RUN: begin
            // Start editing from the time currently shown.
            state    <= ST_SET_HR;
            set_hour <= cur_hour;
            set_min  <= cur_min;
          end
          ST_SET_HR:  state <= ST_SET_MIN;
          ST_SET_MIN: begin
            // Leaving time edit commits it; set_* are untouched in ALM_HR so
            // the clock sees the edited values alongside the strobe.
            state <= ST_ALM_HR;
            load  <= 1'b1;
          end
          ST_ALM_HR:  state <= ST_ALM_MIN;
          ST_ALM_MIN: state <= ST_ALM_EN;
          ST_ALM_EN:  state <= ST_RUN;
          default:    state <= ST_RUN;
        endcase
      end else begin
        case (state)
          ST_RUN: ;
          ST_SET_HR:  if (inc_eff) set_hour  <= set_hour_nx;
          ST_SET_MIN: if (inc_eff) set_min   <= set_min_nx;
          ST_ALM_HR:  if (inc_eff) alarm_hr  <= alarm_hr_nx;
          ST_ALM_MIN: if (inc_eff) alarm_min <= alarm_min_nx;
          ST_ALM_EN:  if (inc_eff) alarm_en  <= ~alarm_en;
          // Codes 6 and 7 cannot be entered; recover to RUN if ever seen.
          default:    state <= ST_RUN;
        endcase
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_setter.sv
// -----------------------------------------------------------------------------
// tb_clock_setter
//
// Directed bench for clock_setter with DEBOUNCE_CYCLES = 4. Each scenario task
// drives the buttons and compares the full output bundle against hand-computed
// values. A monitor counts load pulses and records the outputs seen with each.
// -----------------------------------------------------------------------------
module tb_clock_setter;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       load;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic [2:0] mode;

  int checks = 0;
  int errors = 0;

  // Load monitor.
  int         load_cnt = 0;
  logic [2:0] load_mode;
  logic [4:0] load_hr;
  logic [5:0] load_min;

  // Packed view: {mode, set_hour, set_min, load, alarm_hr, alarm_min, alarm_en}
  logic [26:0] outs;
  assign outs = {mode, set_hour, set_min, load, alarm_hr, alarm_min, alarm_en};

  clock_setter #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cur_hour (cur_hour),
    .cur_min  (cur_min),
    .set_hour (set_hour),
    .set_min  (set_min),
    .load     (load),
    .alarm_hr (alarm_hr),
    .alarm_min(alarm_min),
    .alarm_en (alarm_en),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt  = load_cnt + 1;
      load_mode = mode;
      load_hr   = set_hour;
      load_min  = set_min;
    end
  end

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst      = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  // Hold the selected buttons for 'hold' cycles, then release and let the
  // release debounce fully.
  task automatic press(input logic m, input logic i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    tick(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(10);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(3);
    checks++;
    if (outs !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", outs, 27'd0);
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if (outs !== 27'd0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", outs, 27'd0);
    end
  endtask

  task automatic test_held_through_reset();
    rst      = 1'b1;
    btn_mode = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    checks++;
    if (mode !== 3'd0) begin
      errors++;
      $display("FAIL held_early: mode got %0d expected %0d", mode, 0);
    end
    tick(10);
    checks++;
    if (mode !== 3'd1) begin
      errors++;
      $display("FAIL held_one_event: mode got %0d expected %0d", mode, 1);
    end
    tick(30);
    checks++;
    if (mode !== 3'd1) begin
      errors++;
      $display("FAIL held_no_repeat: mode got %0d expected %0d", mode, 1);
    end
    btn_mode = 1'b0;
    tick(10);
    checks++;
    if (mode !== 3'd1) begin
      errors++;
      $display("FAIL held_release: mode got %0d expected %0d", mode, 1);
    end
  endtask

  task automatic test_run_inc();
    int lc;
    do_reset();
    lc = load_cnt;
    press(1'b0, 1'b1, 8);
    press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== 27'd0 || load_cnt !== lc) begin
      errors++;
      $display("FAIL run_inc: got %h loads %0d expected %h loads %0d", outs, load_cnt, 27'd0, lc);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    press(1'b1, 1'b0, 8);
    checks++;
    if (outs !== {3'd1, 5'd22, 6'd58, 1'b0, 5'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL capture: got %h expected %h", outs, {3'd1, 5'd22, 6'd58, 1'b0, 5'd0, 6'd0, 1'b0});
    end
    press(1'b0, 1'b1, 3);
    checks++;
    if (set_hour !== 5'd22) begin
      errors++;
      $display("FAIL glitch_3: set_hour got %0d expected %0d", set_hour, 22);
    end
    press(1'b0, 1'b1, 10);
    checks++;
    if (set_hour !== 5'd23) begin
      errors++;
      $display("FAIL long_press: set_hour got %0d expected %0d", set_hour, 23);
    end
    press(1'b0, 1'b1, 8);
    checks++;
    if (set_hour !== 5'd0) begin
      errors++;
      $display("FAIL hour_wrap: set_hour got %0d expected %0d", set_hour, 0);
    end
  endtask

  task automatic test_set_sequence();
    int lc;
    do_reset();
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== {3'd1, 5'd0, 6'd58, 1'b0, 5'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL set_hr_wrap: got %h expected %h", outs, {3'd1, 5'd0, 6'd58, 1'b0, 5'd0, 6'd0, 1'b0});
    end
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== {3'd2, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL set_min_wrap: got %h expected %h", outs, {3'd2, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0, 1'b0});
    end
    lc = load_cnt;
    press(1'b1, 1'b0, 8);
    checks++;
    if (load_cnt !== lc + 1) begin
      errors++;
      $display("FAIL load_once: load cycles got %0d expected %0d", load_cnt - lc, 1);
    end
    checks++;
    if ({load_mode, load_hr, load_min} !== {3'd3, 5'd0, 6'd0}) begin
      errors++;
      $display("FAIL load_values: got mode %0d %0d:%0d expected mode 3 0:0", load_mode, load_hr, load_min);
    end
    checks++;
    if (outs !== {3'd3, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL after_load: got %h expected %h", outs, {3'd3, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0, 1'b0});
    end
  endtask

  // Continues from ALM_HR left by test_set_sequence.
  task automatic test_alarm();
    int lc;
    lc = load_cnt;
    press(1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 8);
    for (int k = 0; k < 59; k++) press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== {3'd4, 5'd0, 6'd0, 1'b0, 5'd1, 6'd59, 1'b0}) begin
      errors++;
      $display("FAIL alarm_min_59: got %h expected %h", outs, {3'd4, 5'd0, 6'd0, 1'b0, 5'd1, 6'd59, 1'b0});
    end
    press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== {3'd4, 5'd0, 6'd0, 1'b0, 5'd1, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL alarm_min_wrap: got %h expected %h", outs, {3'd4, 5'd0, 6'd0, 1'b0, 5'd1, 6'd0, 1'b0});
    end
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== {3'd5, 5'd0, 6'd0, 1'b0, 5'd1, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL alarm_en_toggle: got %h expected %h", outs, {3'd5, 5'd0, 6'd0, 1'b0, 5'd1, 6'd0, 1'b1});
    end
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== {3'd0, 5'd0, 6'd0, 1'b0, 5'd1, 6'd0, 1'b1} || load_cnt !== lc) begin
      errors++;
      $display("FAIL back_to_run: got %h loads %0d expected %h loads %0d",
               outs, load_cnt, {3'd0, 5'd0, 6'd0, 1'b0, 5'd1, 6'd0, 1'b1}, lc);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b1, 8);
    checks++;
    if (outs !== {3'd2, 5'd22, 6'd58, 1'b0, 5'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL mode_priority: got %h expected %h", outs, {3'd2, 5'd22, 6'd58, 1'b0, 5'd0, 6'd0, 1'b0});
    end
  endtask

  task automatic test_reset_mid_edit();
    int lc;
    do_reset();
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    checks++;
    if (outs !== {3'd2, 5'd23, 6'd59, 1'b0, 5'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset_edit: got %h expected %h", outs, {3'd2, 5'd23, 6'd59, 1'b0, 5'd0, 6'd0, 1'b0});
    end
    lc = load_cnt;
    // Mode press in flight while reset hits.
    btn_mode = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    checks++;
    if (outs !== 27'd0) begin
      errors++;
      $display("FAIL reset_cycle: got %h expected %h", outs, 27'd0);
    end
    btn_mode = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(20);
    checks++;
    if (outs !== 27'd0 || load_cnt !== lc) begin
      errors++;
      $display("FAIL after_reset_edit: got %h loads %0d expected %h loads %0d", outs, load_cnt, 27'd0, lc);
    end
  endtask

  initial begin
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cur_hour = 5'd22;
    cur_min  = 6'd58;

    test_reset();
    test_held_through_reset();
    test_run_inc();
    test_debounce();
    test_set_sequence();
    test_alarm();
    test_same_cycle();
    test_reset_mid_edit();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
